accel_spi_responder: RTL and testbench
======================================

Name: accel_spi_responder

Overview:
- Synthesizable SPI responder (mode 3, MSB first) emulating the accelerometer at the far end of AccelDriver's SPI bus.
- Runs entirely in the sys_clock domain: oversamples SCL/MOSI/CS, decodes address/command frames, serves a 64x8 register map including DEVID and X/Y/Z data registers.
- Replaces the trivial SimpleSPISlave for bench and board-level loopback; presents a datasheet-shaped register interface so AccelDriver is exercised against realistic frames.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on SCL, MOSI, CS (min 2)
- DEVID, 8'hE5, value returned at address 0x00
- DATA_BASE, 6'h32, first of six read-only data registers (X0,X1,Y0,Y1,Z0,Z1)

Ports:
- sys_clock  in  1  system clock; SCL frequency ≤ sys_clock/8
- reset  in  1  asynchronous, active-low reset
- SCL  in  1  SPI clock from master; idles high
- MOSI  in  1  master-out data
- CS  in  1  chip select, active-low
- MISO  out  1  responder data
- miso_oe  out  1  high while responder drives MISO (read data phase)
- sample_x, sample_y, sample_z  in  16 each  signed samples to publish
- sample_valid  in  1  one-cycle strobe, captures sample_*
- bw_rate  out  8  register 0x2C contents
- power_ctl  out  8  register 0x2D contents
- data_format  out  8  register 0x31 contents
- wr_strobe  out  1  one-cycle pulse per committed register write
- wr_addr  out  6  address of committed write
- wr_data  out  8  data of committed write
- frame_done  out  1  one-cycle pulse on CS rising edge after ≥1 complete byte

Behaviour:
- Reset (reset=0): MISO=0, miso_oe=0, all registers 0x00 except DEVID, wr_strobe=0, frame_done=0, FSM=IDLE, shadow data=0.
- Inputs pass through SYNC_STAGES flops; edges detected on synchronized signals: SCL rise = sample, SCL fall = shift out. CS falling edge -> ADDR; CS high in any state -> IDLE immediately.
- FSM IDLE -> ADDR (CS low) -> DATA (after 8th SCL rise) -> IDLE (CS high).
- ADDR: shift MOSI on SCL rise; byte = {RW, MB, A[5:0]}. RW=1 read, MB=1 auto-increment. MISO=0, miso_oe=0.
- DATA read: at 8th rise of every byte (including address byte), load tx_shift from reg[addr]; miso_oe=1. Each SCL fall: MISO=tx_shift[7], shift left. First data bit appears on the SCL fall after the address byte's 8th rise.
- DATA write: shift MOSI on rise; at 8th rise commit byte to reg[addr] unless addr=0x00 or in DATA_BASE..DATA_BASE+5 (read-only: no write, no wr_strobe). Committed writes pulse wr_strobe the following cycle with wr_addr/wr_data.
- Address update after each data byte: MB=1 -> addr+1, wrapping 0x3F->0x00; MB=0 -> addr unchanged.
- Data registers read little-endian from shadow {x,y,z}. sample_valid with CS high: shadow updates next cycle. With CS low: sample latched into pending, applied on CS rising; multiple pendings, latest wins. Multi-byte read never mixes samples.
- CS high mid-byte: partial byte discarded, no write, miso_oe=0 next cycle, frame_done only if ≥1 full byte received.
- Reset mid-frame: all state returns to reset values; next frame requires fresh CS fall.
- Counters: 3-bit bit count, 6-bit address; no other arithmetic.

Decomposition:
- Package accel_spi_pkg: register address constants (DEVID 0x00, BW_RATE 0x2C, POWER_CTL 0x2D, DATA_FORMAT 0x31, DATAX0 0x32), FSM state enum, RW/MB bit positions; shared with AccelDriver.
- One sub-module: spi_sync_edge (synchronizer plus rise/fall detect), instantiated for SCL, MOSI, CS.

Test Plan:
- Reset low 300 ns, read 0x80 -> MISO byte 0xE5, miso_oe high only during data byte.
- Write 0x2D then 0x08 -> power_ctl=0x08, wr_strobe one pulse with wr_addr=0x2D, wr_data=0x08; frame_done once.
- sample_x=0x0102, y=0x0304, z=0xFFFE, strobe; burst read 0xF2 + 6 bytes -> 02 01 04 03 FE FF.
- Strobe new sample mid-burst -> burst returns old sample; next burst returns new.
- Write 0x40|0x3F with 2 data bytes AA,BB -> reg 0x3F=AA, wrap to 0x00 write blocked (DEVID still E5, single wr_strobe).
- CS deasserted after 4 bits of a write data byte -> no register change, no wr_strobe; reset asserted mid-read -> MISO=0, miso_oe=0 immediately.

Source files
------------

// File: rtl/accel_spi_pkg.sv
// Shared definitions for the accelerometer SPI responder and its driver.
// Holds register addresses, frame bit positions, FSM states and sample bundle.
package accel_spi_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;

    localparam int RW_BIT      = 7;
    localparam int MB_BIT      = 6;
    localparam int N_DATA_REGS = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } spi_state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } sample_t;

    // DEVID and the six sample registers never accept writes.
    function automatic logic is_read_only(input logic [5:0] a,
                                          input logic [5:0] base);
        logic hit;
        hit = (a == ADDR_DEVID);
        for (int i = 0; i < N_DATA_REGS; i++) begin
            if (a == base + 6'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
// Ports: clk_i, rst_ni (async low), d_i raw input; q_o synced, rise_o, fall_o.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-3 responder emulating an accelerometer register map (64x8).
// Ports: sys_clock/reset, SPI pins SCL/MOSI/CS/MISO/miso_oe, sample_* in,
// config registers out, committed-write strobe bundle, frame_done pulse.
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter logic [5:0]  DATA_BASE   = ADDR_DATAX0
) (
    input  logic               sys_clock,
    input  logic               reset,
    input  logic               SCL,
    input  logic               MOSI,
    input  logic               CS,
    output logic               MISO,
    output logic               miso_oe,
    input  logic signed [15:0] sample_x,
    input  logic signed [15:0] sample_y,
    input  logic signed [15:0] sample_z,
    input  logic               sample_valid,
    output logic [7:0]         bw_rate,
    output logic [7:0]         power_ctl,
    output logic [7:0]         data_format,
    output logic               wr_strobe,
    output logic [5:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               frame_done
);

    logic scl_rise, scl_fall, scl_s;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;
    logic unused_edges;

    // SCL idles high; CS resets "low" so a reset released mid-frame
    // cannot fabricate a CS fall and needs a real high-low transition.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
        .clk_i (sys_clock),
        .rst_ni(reset),
        .d_i   (SCL),
        .q_o   (scl_s),
        .rise_o(scl_rise),
        .fall_o(scl_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk_i (sys_clock),
        .rst_ni(reset),
        .d_i   (MOSI),
        .q_o   (mosi_s),
        .rise_o(mosi_rise),
        .fall_o(mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk_i (sys_clock),
        .rst_ni(reset),
        .d_i   (CS),
        .q_o   (cs_s),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    assign unused_edges = &{1'b0, mosi_rise, mosi_fall, scl_s};

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] shift_nx;
    logic [5:0] addr_q, addr_d, addr_nx;
    logic       rw_q, rw_d, mb_q, mb_d;
    logic [7:0] tx_q, tx_d, rd_byte;
    logic       miso_q, miso_d, oe_q, oe_d;
    logic       seen_q, seen_d;
    logic       reg_we;
    logic       wr_stb_q, wr_stb_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       done_q, done_d;
    sample_t    shadow_q, shadow_d, pend_q, pend_d, smp_in;
    logic       pend_v_q, pend_v_d;
    logic [7:0] regs_q [64];

    assign smp_in   = {sample_x, sample_y, sample_z};
    assign shift_nx = {shift_q, mosi_s};

    // Address of the byte to serve/commit after the current 8th rise.
    always_comb begin
        addr_nx = addr_q;
        if (state_q == ST_ADDR) addr_nx = shift_nx[5:0];
        else if (mb_q)          addr_nx = addr_q + 6'd1;
    end

    always_comb begin
        rd_byte = regs_q[addr_nx];
        if (addr_nx == ADDR_DEVID)               rd_byte = DEVID;
        else if (addr_nx == DATA_BASE)           rd_byte = shadow_q.x[7:0];
        else if (addr_nx == DATA_BASE + 6'd1)    rd_byte = shadow_q.x[15:8];
        else if (addr_nx == DATA_BASE + 6'd2)    rd_byte = shadow_q.y[7:0];
        else if (addr_nx == DATA_BASE + 6'd3)    rd_byte = shadow_q.y[15:8];
        else if (addr_nx == DATA_BASE + 6'd4)    rd_byte = shadow_q.z[7:0];
        else if (addr_nx == DATA_BASE + 6'd5)    rd_byte = shadow_q.z[15:8];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        mb_d      = mb_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        seen_d    = seen_q;
        reg_we    = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        if (cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            seen_d    = 1'b0;
            done_d    = cs_rise & seen_q;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_nx[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_DATA;
                            rw_d    = shift_nx[RW_BIT];
                            mb_d    = shift_nx[MB_BIT];
                            addr_d  = addr_nx;
                            seen_d  = 1'b1;
                            if (shift_nx[RW_BIT]) begin
                                tx_d = rd_byte;
                                oe_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_nx[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = addr_nx;
                            if (rw_q) begin
                                tx_d = rd_byte;
                            end else if (!is_read_only(addr_q, DATA_BASE)) begin
                                reg_we    = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = shift_nx;
                            end
                        end
                    end
                    if (scl_fall && rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shadow only moves while CS is high so a burst never mixes samples.
    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (cs_rise && pend_v_q) begin
            shadow_d = pend_q;
            pend_v_d = 1'b0;
        end
        if (sample_valid) begin
            if (cs_s) begin
                shadow_d = smp_in;
                pend_v_d = 1'b0;
            end else begin
                pend_d   = smp_in;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            addr_q    <= 6'd0;
            rw_q      <= 1'b0;
            mb_q      <= 1'b0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            seen_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 8'd0;
            done_q    <= 1'b0;
            shadow_q  <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            mb_q      <= mb_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            seen_q    <= seen_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= 8'd0;
        end else if (reg_we) begin
            regs_q[addr_q] <= shift_nx;
        end
    end

    assign MISO        = miso_q;
    assign miso_oe     = oe_q;
    assign bw_rate     = regs_q[ADDR_BW_RATE];
    assign power_ctl   = regs_q[ADDR_POWER_CTL];
    assign data_format = regs_q[ADDR_DATA_FORMAT];
    assign wr_strobe   = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: mode-3 master, vector table, read scoreboard.
// Hand sequences cover mid-burst sampling, truncated frames and reset mid-read.
module tb_accel_spi_responder;

    localparam int HALF = 80;

    logic sys_clock = 1'b0;
    logic reset = 1'b0;
    logic SCL = 1'b1;
    logic MOSI = 1'b0;
    logic CS = 1'b1;
    logic MISO, miso_oe;
    logic signed [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic sample_valid = 1'b0;
    logic [7:0] bw_rate, power_ctl, data_format, wr_data;
    logic [5:0] wr_addr;
    logic wr_strobe, frame_done;

    always #5 sys_clock = ~sys_clock;

    accel_spi_responder dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .SCL         (SCL),
        .MOSI        (MOSI),
        .CS          (CS),
        .MISO        (MISO),
        .miso_oe     (miso_oe),
        .sample_x    (sample_x),
        .sample_y    (sample_y),
        .sample_z    (sample_z),
        .sample_valid(sample_valid),
        .bw_rate     (bw_rate),
        .power_ctl   (power_ctl),
        .data_format (data_format),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wr_tot = 0;
    int fd_tot = 0;
    logic [5:0] last_wa = '0;
    logic [7:0] last_wd = '0;
    logic [7:0] sb [$];

    always @(negedge sys_clock) begin
        if (wr_strobe) begin
            wr_tot++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (frame_done) fd_tot++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z);
        @(negedge sys_clock);
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        @(negedge sys_clock);
        sample_valid = 1'b0;
    endtask

    // tx holds the frame MSB-first: byte 0 (address) in tx[63:56].
    task automatic do_frame(input logic [63:0] tx, input int n,
                            input int cut, input bit chk_oe);
        logic [63:0] sh;
        logic [7:0] rx, exp_b;
        logic is_rd, oe_ok;
        int nb;
        sh = tx;
        rx = '0;
        is_rd = tx[63];
        oe_ok = 1'b1;
        nb = (cut < 0) ? 8 * n : cut;
        @(negedge sys_clock);
        CS = 1'b0;
        #HALF;
        for (int b = 0; b < nb; b++) begin
            SCL = 1'b0;
            MOSI = sh[63];
            sh = sh << 1;
            #HALF;
            rx = {rx[6:0], MISO};
            if (miso_oe !== (is_rd && b >= 8)) oe_ok = 1'b0;
            SCL = 1'b1;
            #HALF;
            if (is_rd && b >= 8 && (b % 8) == 7) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: got byte %0h, expected none", rx);
                end else begin
                    exp_b = sb.pop_front();
                    chk($sformatf("rd_byte %0d", b / 8), rx, exp_b);
                end
            end
        end
        #HALF;
        CS = 1'b1;
        MOSI = 1'b0;
        #(HALF * 3);
        if (chk_oe) chk("miso_oe_window", oe_ok, 1);
    endtask

    typedef struct {
        int n;
        logic [63:0] tx;
        logic [63:0] rx;
        logic smp;
        logic [15:0] sx, sy, sz;
        int wcnt;
        logic [5:0] wa;
        logic [7:0] wd, bw, pc, df;
    } vec_t;

    function automatic vec_t mkv(input int n, input logic [63:0] tx,
                                 input logic [63:0] rx, input int wcnt,
                                 input logic [5:0] wa, input logic [7:0] wd,
                                 input logic [7:0] bw, input logic [7:0] pc,
                                 input logic [7:0] df);
        vec_t v;
        v.n = n; v.tx = tx; v.rx = rx;
        v.smp = 1'b0; v.sx = '0; v.sy = '0; v.sz = '0;
        v.wcnt = wcnt; v.wa = wa; v.wd = wd;
        v.bw = bw; v.pc = pc; v.df = df;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        int w0, f0;

        vt[0] = mkv(2, 64'h80_00_0000_0000_0000, 64'h00_E5_0000_0000_0000,
                    0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[1] = mkv(2, 64'h2D_08_0000_0000_0000, 64'h0,
                    1, 6'h2D, 8'h08, 8'h00, 8'h08, 8'h00);
        vt[2] = mkv(2, 64'h2C_0A_0000_0000_0000, 64'h0,
                    1, 6'h2C, 8'h0A, 8'h0A, 8'h08, 8'h00);
        vt[3] = mkv(3, 64'h71_0B_5A_00_0000_0000, 64'h0,
                    1, 6'h31, 8'h0B, 8'h0A, 8'h08, 8'h0B);
        vt[4] = mkv(7, 64'hF2_00_0000_0000_0000, 64'h00_02_0104_03FE_FF00,
                    0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h0B);
        vt[4].smp = 1'b1;
        vt[4].sx = 16'h0102; vt[4].sy = 16'h0304; vt[4].sz = 16'hFFFE;
        vt[5] = mkv(3, 64'hAD_00_0000_0000_0000, 64'h00_08_08_00_0000_0000,
                    0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h0B);
        vt[6] = mkv(3, 64'h7F_AA_BB_00_0000_0000, 64'h0,
                    1, 6'h3F, 8'hAA, 8'h0A, 8'h08, 8'h0B);
        vt[7] = mkv(3, 64'hFF_00_0000_0000_0000, 64'h00_AA_E5_00_0000_0000,
                    0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h0B);
        vt[8] = mkv(3, 64'hC0_00_0000_0000_0000, 64'h00_E5_00_00_0000_0000,
                    0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h0B);
        vt[9] = mkv(4, 64'hEC_00_0000_0000_0000, 64'h00_0A_08_00_0000_0000,
                    0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h0B);

        #300;
        chk("rst_miso", MISO, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_bw", bw_rate, 0);
        chk("rst_pc", power_ctl, 0);
        chk("rst_df", data_format, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge sys_clock);
        reset = 1'b1;
        #(HALF * 2);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].smp) strobe(vt[i].sx, vt[i].sy, vt[i].sz);
            if (vt[i].tx[63])
                for (int k = 1; k < vt[i].n; k++)
                    sb.push_back(vt[i].rx[63 - 8 * k -: 8]);
            w0 = wr_tot;
            f0 = fd_tot;
            do_frame(vt[i].tx, vt[i].n, -1, 1);
            chk($sformatf("v%0d wr_cnt", i), wr_tot - w0, vt[i].wcnt);
            if (vt[i].wcnt > 0) begin
                chk($sformatf("v%0d wr_addr", i), last_wa, vt[i].wa);
                chk($sformatf("v%0d wr_data", i), last_wd, vt[i].wd);
            end
            chk($sformatf("v%0d frame_done", i), fd_tot - f0, 1);
            chk($sformatf("v%0d bw_rate", i), bw_rate, vt[i].bw);
            chk($sformatf("v%0d power_ctl", i), power_ctl, vt[i].pc);
            chk($sformatf("v%0d data_format", i), data_format, vt[i].df);
        end

        // New samples mid-burst stay pending; the last one wins afterwards.
        sb.push_back(8'h02); sb.push_back(8'h01);
        sb.push_back(8'h04); sb.push_back(8'h03);
        sb.push_back(8'hFE); sb.push_back(8'hFF);
        fork
            do_frame(64'hF2_00_0000_0000_0000, 7, -1, 1);
            begin
                #(HALF * 40);
                strobe(16'h1111, 16'h2222, 16'h3333);
                #(HALF * 20);
                strobe(16'hA1B2, 16'h0C3D, 16'h8000);
            end
        join
        sb.push_back(8'hB2); sb.push_back(8'hA1);
        sb.push_back(8'h3D); sb.push_back(8'h0C);
        sb.push_back(8'h00); sb.push_back(8'h80);
        do_frame(64'hF2_00_0000_0000_0000, 7, -1, 1);

        // CS raised after 4 data bits of a write.
        w0 = wr_tot;
        f0 = fd_tot;
        do_frame(64'h2C_55_0000_0000_0000, 2, 12, 1);
        chk("cut_wr_cnt", wr_tot - w0, 0);
        chk("cut_bw_rate", bw_rate, 8'h0A);
        chk("cut_frame_done", fd_tot - f0, 1);

        // CS raised inside the address byte: no full byte, no frame_done.
        f0 = fd_tot;
        do_frame(64'h2C_55_0000_0000_0000, 2, 5, 1);
        chk("cut_addr_frame_done", fd_tot - f0, 0);

        // Reset asserted while MISO is driving a '1' of DEVID.
        w0 = wr_tot;
        f0 = fd_tot;
        fork
            do_frame(64'h80_00_0000_0000_0000, 2, 12, 0);
            begin
                @(negedge sys_clock);
                #(HALF * 21 + 60);
                chk("pre_rst_oe", miso_oe, 1);
                chk("pre_rst_miso", MISO, 1);
                reset = 1'b0;
                #1;
                chk("midrst_oe", miso_oe, 0);
                chk("midrst_miso", MISO, 0);
            end
        join
        chk("midrst_frame_done", fd_tot - f0, 0);
        @(negedge sys_clock);
        reset = 1'b1;
        #(HALF * 2);
        chk("post_rst_pc", power_ctl, 0);
        chk("post_rst_bw", bw_rate, 0);
        chk("post_rst_df", data_format, 0);
        sb.push_back(8'hE5);
        do_frame(64'h80_00_0000_0000_0000, 2, -1, 1);
        sb.push_back(8'h00);
        do_frame(64'hAD_00_0000_0000_0000, 2, -1, 1);
        chk("post_rst_wr_cnt", wr_tot - w0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1);
    end

endmodule
